// File: rtl/udma_tx_arb_pkg.sv
// Shared types and data-alignment helper for the uDMA TX channel arbiter.
package udma_tx_arb_pkg;

  localparam int unsigned CH_ID_W = 3;

  typedef enum logic [1:0] {
    DS_BYTE = 2'd0,
    DS_HALF = 2'd1,
    DS_WORD = 2'd2
  } datasize_e;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch_id;
    datasize_e          datasize;
    logic [1:0]         byte_off;
  } tag_t;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch_id;
    logic [31:0]        data;
  } resp_t;

  // Encoding 3 is folded onto word so the enum never holds an undeclared value.
  function automatic datasize_e decode_ds(logic [1:0] raw);
    return (raw == 2'd3) ? DS_WORD : datasize_e'(raw);
  endfunction

  function automatic logic [31:0] align_data(logic [31:0] rdata, datasize_e ds, logic [1:0] off);
    logic [31:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (ds)
      DS_BYTE: return {24'h0, shifted[7:0]};
      DS_HALF: return {16'h0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/udma_sync_fifo.sv
// Generic synchronous FIFO with full/empty flags; Depth must be a power of two.
module udma_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assert property (@(posedge sys_clk_i) disable iff (rst_i) !(push_i && full_o))
    else $error("udma_sync_fifo: push while full");
  assert property (@(posedge sys_clk_i) disable iff (rst_i) !(pop_i && empty_o))
    else $error("udma_sync_fifo: pop while empty");

endmodule

// File: rtl/udma_tx_ch_arbiter.sv
// Round-robin arbiter of N peripheral TX read channels onto one L2 read port,
// with in-order tag tracking and aligned, credit-limited response return.
module udma_tx_ch_arbiter
  import udma_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic                               sys_clk_i,
  input  logic                               rst_i,
  input  logic [NUM_CH-1:0]                  ch_req_i,
  input  logic [NUM_CH*L2_AWIDTH_NOAL-1:0]   ch_addr_i,
  input  logic [NUM_CH*2-1:0]                ch_datasize_i,
  output logic [NUM_CH-1:0]                  ch_gnt_o,
  output logic [31:0]                        ch_data_o,
  output logic [NUM_CH-1:0]                  ch_valid_o,
  input  logic [NUM_CH-1:0]                  ch_ready_i,
  output logic                               l2_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]          l2_addr_o,
  input  logic                               l2_gnt_i,
  input  logic [31:0]                        l2_rdata_i,
  input  logic                               l2_rvalid_i,
  output logic                               busy_o
);

  localparam int unsigned AW       = L2_AWIDTH_NOAL;
  localparam int unsigned CREDIT_W = $clog2(OUTSTANDING + 1);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("udma_tx_ch_arbiter supports DATA_WIDTH == 32 only");
  end

  logic [CH_ID_W-1:0]  rr_q, rr_d;
  logic [CH_ID_W-1:0]  win_id, win_hi, win_lo;
  logic                found_hi, found_lo, win_valid;
  logic [AW-1:0]       win_addr;
  logic [1:0]          win_ds_raw;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                grant;

  tag_t  tag_in, tag_head;
  resp_t resp_in, resp_head;
  logic  tag_full, tag_empty, tag_pop;
  logic  resp_full, resp_empty, resp_push, resp_pop;

  // Two-pass priority search: first requester at/after rr_q, else first from 0.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      if (ch_req_i[j]) begin
        if (!found_hi && (j >= int'(rr_q))) begin
          found_hi = 1'b1;
          win_hi   = CH_ID_W'(j);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = CH_ID_W'(j);
        end
      end
    end
    win_valid  = found_hi || found_lo;
    win_id     = found_hi ? win_hi : win_lo;
    win_addr   = '0;
    win_ds_raw = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      if (win_id == CH_ID_W'(j)) begin
        win_addr   = ch_addr_i[j*AW +: AW];
        win_ds_raw = ch_datasize_i[j*2 +: 2];
      end
    end
  end

  assign l2_req_o  = win_valid && (credit_q < CREDIT_W'(OUTSTANDING));
  assign l2_addr_o = l2_req_o ? {win_addr[AW-1:2], 2'b00} : '0;
  assign grant     = l2_req_o && l2_gnt_i;

  always_comb begin
    ch_gnt_o = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      ch_gnt_o[j] = grant && (win_id == CH_ID_W'(j));
    end
    rr_d = rr_q;
    if (grant) begin
      rr_d = (win_id == CH_ID_W'(NUM_CH - 1)) ? '0 : win_id + CH_ID_W'(1);
    end
  end

  assign tag_in  = '{ch_id: win_id, datasize: decode_ds(win_ds_raw), byte_off: win_addr[1:0]};
  assign tag_pop = l2_rvalid_i && !tag_empty;

  udma_sync_fifo #(
    .Width ($bits(tag_t)),
    .Depth (OUTSTANDING)
  ) u_tag_fifo (
    .sys_clk_i (sys_clk_i),
    .rst_i     (rst_i),
    .push_i    (grant),
    .wdata_i   (tag_in),
    .pop_i     (tag_pop),
    .rdata_o   (tag_head),
    .full_o    (tag_full),
    .empty_o   (tag_empty)
  );

  assign resp_push = tag_pop;
  assign resp_in   = '{ch_id: tag_head.ch_id,
                       data:  align_data(l2_rdata_i, tag_head.datasize, tag_head.byte_off)};

  udma_sync_fifo #(
    .Width ($bits(resp_t)),
    .Depth (OUTSTANDING)
  ) u_resp_fifo (
    .sys_clk_i (sys_clk_i),
    .rst_i     (rst_i),
    .push_i    (resp_push),
    .wdata_i   (resp_in),
    .pop_i     (resp_pop),
    .rdata_o   (resp_head),
    .full_o    (resp_full),
    .empty_o   (resp_empty)
  );

  // The response FIFO storage is the output register; only its head is exposed.
  always_comb begin
    ch_valid_o = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      ch_valid_o[j] = !resp_empty && (resp_head.ch_id == CH_ID_W'(j));
    end
  end

  assign ch_data_o = resp_empty ? '0 : resp_head.data;
  assign resp_pop  = |(ch_valid_o & ch_ready_i);

  always_comb begin
    credit_d = credit_q;
    case ({grant, resp_pop})
      2'b10:   credit_d = credit_q + CREDIT_W'(1);
      2'b01:   credit_d = credit_q - CREDIT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      credit_q <= '0;
    end else begin
      rr_q     <= rr_d;
      credit_q <= credit_d;
    end
  end

  assign busy_o = (credit_q != '0);

  assert property (@(posedge sys_clk_i) disable iff (rst_i) !(l2_rvalid_i && tag_empty))
    else $error("udma_tx_ch_arbiter: l2_rvalid_i with no read outstanding");
  assert property (@(posedge sys_clk_i) disable iff (rst_i)
                   !((grant && tag_full) || (resp_push && resp_full)))
    else $error("udma_tx_ch_arbiter: FIFO overflow");
  assert property (@(posedge sys_clk_i) disable iff (rst_i) credit_q <= CREDIT_W'(OUTSTANDING))
    else $error("udma_tx_ch_arbiter: credit out of range");

endmodule

// File: tb/tb_udma_tx_ch_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_udma_tx_ch_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int OUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*2-1:0]  ch_ds;
  logic [NCH-1:0]    ch_gnt;
  logic [31:0]       ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic              l2_req;
  logic [AW-1:0]     l2_addr;
  logic              l2_gnt;
  logic [31:0]       l2_rdata;
  logic              l2_rvalid;
  logic              busy;

  always #5 clk = ~clk;

  udma_tx_ch_arbiter #(
    .NUM_CH         (NCH),
    .L2_AWIDTH_NOAL (AW),
    .DATA_WIDTH     (32),
    .OUTSTANDING    (OUT)
  ) dut (
    .sys_clk_i     (clk),
    .rst_i         (rst),
    .ch_req_i      (ch_req),
    .ch_addr_i     (ch_addr),
    .ch_datasize_i (ch_ds),
    .ch_gnt_o      (ch_gnt),
    .ch_data_o     (ch_data),
    .ch_valid_o    (ch_valid),
    .ch_ready_i    (ch_ready),
    .l2_req_o      (l2_req),
    .l2_addr_o     (l2_addr),
    .l2_gnt_i      (l2_gnt),
    .l2_rdata_i    (l2_rdata),
    .l2_rvalid_i   (l2_rvalid),
    .busy_o        (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_req    = '0;
    ch_addr   = '0;
    ch_ds     = '0;
    ch_ready  = '0;
    l2_gnt    = 1'b0;
    l2_rvalid = 1'b0;
    l2_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [1:0] ds);
    ch_req[ch]          = 1'b1;
    ch_addr[ch*AW +: AW] = a;
    ch_ds[ch*2 +: 2]     = ds;
  endtask

  // Byte-lane extraction: lane k of the result is byte (off+k) of the word.
  function automatic logic [31:0] ref_align(logic [31:0] rd, int ds, int off);
    logic [31:0] r;
    int nb;
    nb = (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    r  = '0;
    for (int k = 0; k < nb; k++) begin
      if (off + k < 4) r[8*k +: 8] = rd[8*(off+k) +: 8];
    end
    return r;
  endfunction

  typedef struct {
    int          ch;
    logic [11:0] addr;
    logic [1:0]  ds;
    logic [31:0] rdata;
    logic [11:0] exp_l2;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct { int ch; int ds; int off; } mtag_t;
  typedef struct { int ch; logic [31:0] data; } mresp_t;

  vec_t   vecs[8];
  mtag_t  tagq[$];
  mresp_t respq[$];
  mtag_t  t;
  mresp_t r;
  int     rr_m, credit_m, w;
  logic   exp_req, pop_m;
  logic [NCH-1:0] exp_gnt, exp_valid, last_gnt;
  logic [AW-1:0]  exp_addr;

  initial begin
    vecs[0] = '{0, 12'h004, 2'd2, 32'hDEADBEEF, 12'h004, 32'hDEADBEEF};
    vecs[1] = '{2, 12'h013, 2'd0, 32'h11223344, 12'h010, 32'h00000011};
    vecs[2] = '{2, 12'h012, 2'd1, 32'h11223344, 12'h010, 32'h00001122};
    vecs[3] = '{3, 12'h001, 2'd0, 32'hA1B2C3D4, 12'h000, 32'h000000C3};
    vecs[4] = '{1, 12'h00E, 2'd1, 32'hABCD1234, 12'h00C, 32'h0000ABCD};
    vecs[5] = '{1, 12'h7F8, 2'd3, 32'hCAFEF00D, 12'h7F8, 32'hCAFEF00D};
    vecs[6] = '{0, 12'h003, 2'd2, 32'h11223344, 12'h000, 32'h00000011};
    vecs[7] = '{3, 12'hFFD, 2'd1, 32'h87654321, 12'hFFC, 32'h00006543};

    rst = 1'b1;
    idle_inputs();
    #2;
    check("rst_gnt", 32'(ch_gnt), 32'h0);
    check("rst_valid", 32'(ch_valid), 32'h0);
    check("rst_data", ch_data, 32'h0);
    check("rst_l2_req", 32'(l2_req), 32'h0);
    check("rst_l2_addr", 32'(l2_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single transactions: grant, address, alignment and 1-cycle return latency
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].ch, vecs[v].addr, vecs[v].ds);
      l2_gnt = 1'b1;
      #1;
      check($sformatf("vec%0d_l2_req", v), 32'(l2_req), 32'h1);
      check($sformatf("vec%0d_l2_addr", v), 32'(l2_addr), 32'(vecs[v].exp_l2));
      check($sformatf("vec%0d_gnt", v), 32'(ch_gnt), 32'(1 << vecs[v].ch));
      tick();
      ch_req = '0;
      l2_gnt = 1'b0;
      tick();
      l2_rvalid = 1'b1;
      l2_rdata  = vecs[v].rdata;
      #1;
      check($sformatf("vec%0d_early", v), 32'(ch_valid), 32'h0);
      tick();
      l2_rvalid = 1'b0;
      l2_rdata  = '0;
      check($sformatf("vec%0d_valid", v), 32'(ch_valid), 32'(1 << vecs[v].ch));
      check($sformatf("vec%0d_data", v), ch_data, vecs[v].exp_data);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'h1);
      ch_ready[vecs[v].ch] = 1'b1;
      tick();
      ch_ready = '0;
      check($sformatf("vec%0d_popped", v), 32'(ch_valid), 32'h0);
      check($sformatf("vec%0d_idle", v), 32'(busy), 32'h0);
    end

    // Round-robin order and credit exhaustion
    do_reset();
    for (int k = 0; k < NCH; k++) set_req(k, 12'(12'h100 + 4 * k), 2'd2);
    l2_gnt = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), 32'(ch_gnt), 32'(1 << i));
      tick();
    end
    #1;
    check("credit_full_req", 32'(l2_req), 32'h0);
    check("credit_full_gnt", 32'(ch_gnt), 32'h0);
    check("credit_full_busy", 32'(busy), 32'h1);
    l2_rvalid = 1'b1;
    l2_rdata  = 32'h00000055;
    tick();
    l2_rvalid = 1'b0;
    check("credit_resp_valid", 32'(ch_valid), 32'h1);
    check("credit_resp_data", ch_data, 32'h55);
    check("credit_still_full", 32'(l2_req), 32'h0);
    ch_ready = '1;
    tick();
    ch_ready = '0;
    check("credit_back_req", 32'(l2_req), 32'h1);
    check("credit_back_gnt", 32'(ch_gnt), 32'h1);
    tick();
    ch_req   = '0;
    l2_gnt   = 1'b0;
    ch_ready = '1;
    for (int i = 0; i < OUT; i++) begin
      l2_rvalid = 1'b1;
      tick();
    end
    l2_rvalid = 1'b0;
    tick();
    tick();
    ch_ready = '0;
    check("drain_busy", 32'(busy), 32'h0);
    check("drain_valid", 32'(ch_valid), 32'h0);

    // Head-of-line blocking: ch1 not ready holds ch3 behind it
    do_reset();
    set_req(1, 12'h020, 2'd2);
    l2_gnt = 1'b1;
    #1;
    check("hol_gnt1", 32'(ch_gnt), 32'h2);
    tick();
    ch_req = '0;
    set_req(3, 12'h031, 2'd0);
    #1;
    check("hol_gnt3", 32'(ch_gnt), 32'h8);
    tick();
    ch_req    = '0;
    l2_gnt    = 1'b0;
    ch_ready  = 4'b1000;
    l2_rvalid = 1'b1;
    l2_rdata  = 32'h0BADF00D;
    tick();
    l2_rdata = 32'h44332211;
    tick();
    l2_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hol_hold_valid%0d", i), 32'(ch_valid), 32'h2);
      check($sformatf("hol_hold_data%0d", i), ch_data, 32'h0BADF00D);
      tick();
    end
    ch_ready[1] = 1'b1;
    tick();
    ch_ready[1] = 1'b0;
    check("hol_next_valid", 32'(ch_valid), 32'h8);
    check("hol_next_data", ch_data, 32'h00000022);
    tick();
    ch_ready = '0;
    check("hol_done_valid", 32'(ch_valid), 32'h0);
    check("hol_done_busy", 32'(busy), 32'h0);

    // Reset with reads in flight; stray rvalid pulses must leave nothing behind
    do_reset();
    for (int k = 0; k < 3; k++) set_req(k, 12'(12'h200 + 4 * k), 2'd2);
    l2_gnt = 1'b1;
    tick();
    tick();
    tick();
    ch_req = '0;
    l2_gnt = 1'b0;
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_req", 32'(l2_req), 32'h0);
    check("mid_rst_valid", 32'(ch_valid), 32'h0);
    check("mid_rst_data", ch_data, 32'h0);
    tick();
    l2_rvalid = 1'b1;
    l2_rdata  = 32'hFFFFFFFF;
    tick();
    l2_rvalid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid%0d", i), 32'(ch_valid), 32'h0);
      check($sformatf("post_rst_busy%0d", i), 32'(busy), 32'h0);
    end

    // Randomized traffic against the queue model
    do_reset();
    rr_m     = 0;
    credit_m = 0;
    last_gnt = '0;
    tagq.delete();
    respq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NCH; k++) begin
        if (last_gnt[k]) begin
          ch_req[k] = 1'b0;
          if ($urandom_range(1) == 1) set_req(k, 12'($urandom), 2'($urandom));
        end else if (ch_req[k]) begin
          if ($urandom_range(9) == 0) ch_req[k] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          set_req(k, 12'($urandom), 2'($urandom));
        end
      end
      l2_gnt    = ($urandom_range(3) != 0);
      ch_ready  = NCH'($urandom);
      l2_rdata  = $urandom;
      l2_rvalid = (tagq.size() > 0) && ($urandom_range(1) == 1);
      #1;
      w = -1;
      for (int i = 0; i < NCH; i++) begin
        if (w < 0 && ch_req[(rr_m + i) % NCH]) w = (rr_m + i) % NCH;
      end
      exp_req  = (w >= 0) && (credit_m < OUT);
      exp_gnt  = (exp_req && l2_gnt) ? NCH'(1 << w) : '0;
      exp_addr = exp_req ? (ch_addr[w*AW +: AW] & ~12'h3) : '0;
      exp_valid = (respq.size() > 0) ? NCH'(1 << respq[0].ch) : '0;
      check($sformatf("rnd%0d_l2_req", cyc), 32'(l2_req), 32'(exp_req));
      check($sformatf("rnd%0d_gnt", cyc), 32'(ch_gnt), 32'(exp_gnt));
      if (exp_req) check($sformatf("rnd%0d_l2_addr", cyc), 32'(l2_addr), 32'(exp_addr));
      check($sformatf("rnd%0d_valid", cyc), 32'(ch_valid), 32'(exp_valid));
      if (respq.size() > 0) check($sformatf("rnd%0d_data", cyc), ch_data, respq[0].data);
      check($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(credit_m != 0));

      pop_m = (respq.size() > 0) && ch_ready[respq[0].ch];
      if (pop_m) begin
        void'(respq.pop_front());
        credit_m--;
      end
      if (l2_rvalid) begin
        t = tagq.pop_front();
        r.ch   = t.ch;
        r.data = ref_align(l2_rdata, t.ds, t.off);
        respq.push_back(r);
      end
      if (exp_gnt != '0) begin
        t.ch  = w;
        t.ds  = int'(ch_ds[w*2 +: 2]);
        t.off = int'(ch_addr[w*AW +: 2]);
        tagq.push_back(t);
        rr_m = (w + 1) % NCH;
        credit_m++;
      end
      last_gnt = exp_gnt;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
